pc_count_register_16: RTL and testbench



---
 rtl/pc_count_register_16.sv | 61 ++++++
 tb/tb_pc_count_register_16.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pc_count_register_16.sv
// pc_count_register_16: run/stop counter register looped around an external incrementer, with load, sticky overflow and valid/ready output.
// Optional terminal count (term_val input, tc output) enabled by defining PC_COUNT_TERM_EN.
module pc_count_register_16 #(
  parameter bit          STOP_ON_WRAP = 1'b0,
  parameter logic [15:0] RESET_VAL    = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic [15:0] inc_s,
  input  logic        inc_c,
  output logic [15:0] q,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        ovf
`ifdef PC_COUNT_TERM_EN
  ,
  input  logic [15:0] term_val,
  output logic        tc
`endif
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic accept, step, term_hit;
  always_comb begin
    accept = out_valid & out_ready;
    step = (state == RUN) & ~stop & ~load & (~out_valid | accept);
`ifdef PC_COUNT_TERM_EN
    term_hit = step & (inc_s == term_val);
`else
    term_hit = 1'b0;
`endif
    state_n = (state == IDLE) ? ((start & ~stop) ? RUN : IDLE)
            : ((stop | (step & inc_c & STOP_ON_WRAP) | term_hit) ? IDLE : RUN);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      q         <= RESET_VAL;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
`ifdef PC_COUNT_TERM_EN
      tc        <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      busy      <= state_n == RUN;
      q         <= load ? load_val : step ? inc_s : q;
      out_valid <= load | step | (out_valid & ~out_ready);
      ovf       <= ~load & (ovf | (step & inc_c));
`ifdef PC_COUNT_TERM_EN
      tc        <= ~load & ~((state == IDLE) & (state_n == RUN)) & (tc | term_hit);
`endif
    end
  end
endmodule

// File: tb/tb_pc_count_register_16.sv
// tb_pc_count_register_16: directed bench; dut0 uses default parameters, dut1 uses STOP_ON_WRAP=1 and a nonzero reset value.
module tb_pc_count_register_16;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, load = 1'b0, out_ready = 1'b1;
  logic [15:0] load_val = 16'h0000;
  logic [15:0] q0, q1, s0, s1;
  logic c0, c1, v0, v1, b0, b1, o0, o1;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  assign {c0, s0} = {1'b0, q0} + 17'd1;
  assign {c1, s1} = {1'b0, q1} + 17'd1;
`ifdef PC_COUNT_TERM_EN
  logic [15:0] term_val = 16'hBEEF;
  logic tc0, tc1;
`endif
  pc_count_register_16 dut0 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .load(load), .load_val(load_val),
    .inc_s(s0), .inc_c(c0), .q(q0), .out_valid(v0), .out_ready(out_ready), .busy(b0), .ovf(o0)
`ifdef PC_COUNT_TERM_EN
    , .term_val(term_val), .tc(tc0)
`endif
  );
  pc_count_register_16 #(.STOP_ON_WRAP(1'b1), .RESET_VAL(16'h1230)) dut1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .load(load), .load_val(load_val),
    .inc_s(s1), .inc_c(c1), .q(q1), .out_valid(v1), .out_ready(out_ready), .busy(b1), .ovf(o1)
`ifdef PC_COUNT_TERM_EN
    , .term_val(term_val), .tc(tc1)
`endif
  );
  task automatic test_reset;
    reset = 1'b1; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    tests++; if (q0 !== 16'h0000) begin fails++; $display("FAIL reset_q0 got %h exp 0000", q0); end
    tests++; if (q1 !== 16'h1230) begin fails++; $display("FAIL reset_q1 got %h exp 1230", q1); end
    tests++; if ({v0, b0, o0} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b exp 000", {v0, b0, o0}); end
  endtask
  task automatic test_count;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++; if ({b0, v0, q0} !== {2'b10, 16'h0000}) begin fails++; $display("FAIL start_edge got b=%b v=%b q=%h exp b=1 v=0 q=0000", b0, v0, q0); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      tests++; if ({b0, v0, q0} !== {2'b11, 16'(i)}) begin fails++; $display("FAIL count%0d got b=%b v=%b q=%h exp b=1 v=1 q=%h", i, b0, v0, q0, 16'(i)); end
    end
  endtask
  task automatic test_stall;
    @(negedge clk); @(negedge clk);
    tests++; if (q0 !== 16'h0005) begin fails++; $display("FAIL pre_stall got %h exp 0005", q0); end
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++; if ({v0, q0} !== {1'b1, 16'h0005}) begin fails++; $display("FAIL stall%0d got v=%b q=%h exp v=1 q=0005", i, v0, q0); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    tests++; if (q0 !== 16'h0006) begin fails++; $display("FAIL unstall got %h exp 0006", q0); end
  endtask
  task automatic test_wrap;
    load = 1'b1; load_val = 16'hFFFE;
    @(negedge clk);
    load = 1'b0;
    tests++; if ({v0, o0, q0} !== {2'b10, 16'hFFFE}) begin fails++; $display("FAIL load_fffe got v=%b o=%b q=%h exp v=1 o=0 q=fffe", v0, o0, q0); end
    @(negedge clk);
    tests++; if ({o0, q0} !== {1'b0, 16'hFFFF}) begin fails++; $display("FAIL to_ffff got o=%b q=%h exp o=0 q=ffff", o0, q0); end
    @(negedge clk);
    tests++; if ({b0, o0, q0} !== {2'b11, 16'h0000}) begin fails++; $display("FAIL wrap0 got b=%b o=%b q=%h exp b=1 o=1 q=0000", b0, o0, q0); end
    tests++; if ({b1, o1, q1} !== {2'b01, 16'h0000}) begin fails++; $display("FAIL wrap1 got b=%b o=%b q=%h exp b=0 o=1 q=0000", b1, o1, q1); end
    @(negedge clk);
    tests++; if ({o0, q0} !== {1'b1, 16'h0001}) begin fails++; $display("FAIL ovf_sticky got o=%b q=%h exp o=1 q=0001", o0, q0); end
    tests++; if (q1 !== 16'h0000) begin fails++; $display("FAIL wrap_hold1 got %h exp 0000", q1); end
  endtask
  task automatic test_load_clears_ovf;
    load = 1'b1; load_val = 16'h0100;
    @(negedge clk);
    load = 1'b0;
    tests++; if ({v0, o0, q0} !== {2'b10, 16'h0100}) begin fails++; $display("FAIL ovf_clr0 got v=%b o=%b q=%h exp v=1 o=0 q=0100", v0, o0, q0); end
    tests++; if ({b1, v1, o1, q1} !== {3'b010, 16'h0100}) begin fails++; $display("FAIL idle_load1 got b=%b v=%b o=%b q=%h exp b=0 v=1 o=0 q=0100", b1, v1, o1, q1); end
  endtask
  task automatic test_stop;
    @(negedge clk);
    tests++; if (q0 !== 16'h0101) begin fails++; $display("FAIL pre_stop got %h exp 0101", q0); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    tests++; if ({b0, v0, q0} !== {2'b00, 16'h0101}) begin fails++; $display("FAIL stop got b=%b v=%b q=%h exp b=0 v=0 q=0101", b0, v0, q0); end
    @(negedge clk);
    tests++; if (q0 !== 16'h0101) begin fails++; $display("FAIL idle_hold got %h exp 0101", q0); end
  endtask
  task automatic test_reset_priority;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; load = 1'b1; load_val = 16'h0010;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk); @(negedge clk);
    tests++; if ({b0, q0} !== {1'b1, 16'h0012}) begin fails++; $display("FAIL pre_reset got b=%b q=%h exp b=1 q=0012", b0, q0); end
    reset = 1'b1; load = 1'b1; load_val = 16'hABCD; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; load = 1'b0; start = 1'b0;
    tests++; if ({b0, v0, o0, q0} !== {3'b000, 16'h0000}) begin fails++; $display("FAIL reset_load0 got b=%b v=%b o=%b q=%h exp 0 0 0 0000", b0, v0, o0, q0); end
    tests++; if ({b1, v1, q1} !== {2'b00, 16'h1230}) begin fails++; $display("FAIL reset_load1 got b=%b v=%b q=%h exp 0 0 1230", b1, v1, q1); end
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    tests++; if ({b0, q0} !== {1'b0, 16'h0000}) begin fails++; $display("FAIL start_stop got b=%b q=%h exp b=0 q=0000", b0, q0); end
  endtask
`ifdef PC_COUNT_TERM_EN
  task automatic test_term;
    term_val = 16'h0003; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    tests++; if ({tc0, b0, q0} !== {2'b10, 16'h0003}) begin fails++; $display("FAIL term got tc=%b b=%b q=%h exp tc=1 b=0 q=0003", tc0, b0, q0); end
    @(negedge clk);
    tests++; if (q0 !== 16'h0003) begin fails++; $display("FAIL term_hold got %h exp 0003", q0); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++; if ({tc0, b0} !== 2'b01) begin fails++; $display("FAIL tc_clear got tc=%b b=%b exp tc=0 b=1", tc0, b0); end
  endtask
`endif
  initial begin
    test_reset();
    test_count();
    test_stall();
    test_wrap();
    test_load_clears_ovf();
    test_stop();
    test_reset_priority();
`ifdef PC_COUNT_TERM_EN
    test_term();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
